bit_serializer: RTL

- Parallel-to-serial stage that converts DATA_W-bit words into a one-bit-per-clock stream.
- Its outputs bit_out and bit_valid drive the x input of the downstream serial pattern detectors, such as the Mealy "101" detector.
- It accepts words through a valid/ready handshake.
- Back-to-back words are emitted with no idle gap, so detector patterns that span word boundaries are preserved.

---
 rtl/serial_pkg.sv | 25 ++
 rtl/bit_serializer_if.sv | 44 ++++
 rtl/bit_serializer.sv | 116 +++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial bit-stream path: the serializer state
// encoding, the counter-width helper and the default idle line level. The
// downstream serial pattern detectors use the same idle level, so an idle
// serializer never looks like data to them.
// No ports (package).
// -----------------------------------------------------------------------------
package serial_pkg;

    // Serializer state. IDLE: no word in flight. SHIFT: emitting bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Line level driven whenever no real data bit is on the wire.
    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Width of a counter that must hold values 0 .. data_w-1.
    function automatic int cnt_width(input int data_w);
        return (data_w > 1) ? $clog2(data_w) : 1;
    endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// -----------------------------------------------------------------------------
// bit_serializer_if
// Groups the word-input handshake and the serial-output signals of the
// bit serializer.
//
// Handshake: a word moves from the upstream source into the serializer on
// every rising clk edge where s_valid and s_ready are both 1. s_valid may be
// raised at any time and s_data may change freely while s_ready is 0; only
// the s_data value present at the transfer edge is taken. s_ready is
// combinational and never depends on s_valid.
//
// Signals:
//   s_data      word to serialize            (source -> serializer)
//   s_valid     s_data is valid              (source -> serializer)
//   s_ready     serializer can take a word   (serializer -> source)
//   flush       abort the word in flight     (source -> serializer)
//   bit_out     serial data bit, registered  (serializer -> sink)
//   bit_valid   bit_out is a real data bit   (serializer -> sink)
//   frame_start first bit of a word          (serializer -> sink)
//   frame_end   last bit of a word           (serializer -> sink)
// Modports: master = upstream source / bench driver, slave = serializer.
// -----------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              flush;
    logic              bit_out;
    logic              bit_valid;
    logic              frame_start;
    logic              frame_end;

    modport master (
        output s_data, s_valid, flush,
        input  s_ready, bit_out, bit_valid, frame_start, frame_end
    );

    modport slave (
        input  s_data, s_valid, flush,
        output s_ready, bit_out, bit_valid, frame_start, frame_end
    );
endinterface

// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial stage: turns DATA_W-bit words into one bit per clock.
// Back-to-back words are chained with no idle cycle so that serial patterns
// spanning word boundaries reach the downstream detectors intact.
//
// Parameters:
//   DATA_W    word width (>= 2)
//   MSB_FIRST 1: bit DATA_W-1 leaves first, 0: bit 0 leaves first
//   IDLE_BIT  level of bit_out whenever bit_valid = 0
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   bus          bit_serializer_if.slave (handshake in, serial stream out)
//   dbg_state_o  current FSM state, for observation only
//
// Every output except s_ready is taken straight from a flop, so the stream
// can feed a registered Mealy detector without extra staging.
// -----------------------------------------------------------------------------
module bit_serializer
    import serial_pkg::*;
#(
    parameter int   DATA_W    = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    bit_serializer_if.slave bus,
    output state_e          dbg_state_o
);

    localparam int               CNT_W    = cnt_width(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              bit_out_q, bit_out_d;
    logic              bit_valid_q, bit_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              frame_end_q, frame_end_d;

    logic ready;
    logic accept;

    // Ready in IDLE, and also on the last bit of a word so the next word
    // loads on the same edge that would otherwise drop back to IDLE.
    assign ready  = !reset && !bus.flush &&
                    (state_q == IDLE || (state_q == SHIFT && cnt_q == '0));
    assign accept = bus.s_valid && ready;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shreg_d       = shreg_q;
        frame_start_d = 1'b0;

        if (bus.flush) begin
            // Flush wins over an accept; ready is already 0 here.
            state_d = IDLE;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (accept) begin
            state_d       = SHIFT;
            cnt_d         = CNT_LAST;
            shreg_d       = bus.s_data;
            frame_start_d = 1'b1;
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                cnt_d   = cnt_q - CNT_W'(1);
                shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
            end else begin
                state_d = IDLE;
            end
        end

        // Output flops are loaded from next-state values, so the bit shown in
        // a cycle is the output-end bit of the register held in that cycle.
        bit_valid_d = (state_d == SHIFT);
        if (bit_valid_d) begin
            bit_out_d = MSB_FIRST ? shreg_d[DATA_W-1] : shreg_d[0];
        end else begin
            bit_out_d = IDLE_BIT;
        end
        frame_end_d = bit_valid_d && (cnt_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            shreg_q       <= '0;
            bit_out_q     <= IDLE_BIT;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shreg_q       <= shreg_d;
            bit_out_q     <= bit_out_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
        end
    end

    assign bus.s_ready     = ready;
    assign bus.bit_out     = bit_out_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign dbg_state_o     = state_q;

endmodule
